// File: rtl/qspi_mem_target_if.sv
// Quad-SPI bus pins between a flash/PSRAM master and the memory target.
// master drives chip select and outbound data; slave answers on dq_out/dq_oe.
interface qspi_mem_target_if;
  logic       cs_n;
  logic [3:0] dq_in;
  logic [3:0] dq_out;
  logic [3:0] dq_oe;

  modport master (output cs_n, dq_in, input dq_out, dq_oe);
  modport slave  (input cs_n, dq_in, output dq_out, dq_oe);
endinterface

// File: rtl/qspi_mem_target.sv
// Quad-SPI memory responder: decodes 0xEB quad reads and 0x38 quad writes
// and serves them from a byte-wide synchronous RAM port.
//
// state   | meaning
// IDLE    | waiting for cs_n low (only once armed)
// CMD     | second opcode nibble
// ADDR    | six address nibbles, MSB first
// DUMMY   | read turnaround; first byte is fetched here
// RDATA   | streaming read nibbles, next byte prefetched
// WDATA   | collecting write nibbles, one RAM write per byte
// IGNORE  | unsupported opcode, silent until cs_n high
module qspi_mem_target #(
  parameter int          AW     = 24,
  parameter int          DUMMY  = 6,
  parameter logic [7:0]  RD_CMD = 8'hEB,
  parameter logic [7:0]  WR_CMD = 8'h38
) (
  input  logic             clk,
  input  logic             reset,
  qspi_mem_target_if.slave bus,
  output logic [AW-1:0]    mem_addr,
  output logic             mem_re,
  input  logic [7:0]       mem_rdata,
  output logic             mem_we,
  output logic [7:0]       mem_wdata,
  output logic             busy,
  output logic             cmd_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_RDATA, S_WDATA, S_IGNORE
  } state_t;

  state_t        state, state_nxt;
  logic          armed;
  logic [7:0]    op;
  logic [19:0]   a_sh;
  logic [3:0]    cnt;
  logic          ph;
  logic          re_d;
  logic [7:0]    rbuf;
  logic [3:0]    whi;
  logic [AW-1:0] addr;

  logic          is_rd, is_wr;
  logic [23:0]   a_full;
  logic [7:0]    rsrc;

  assign is_rd  = (op == RD_CMD);
  assign is_wr  = (op == WR_CMD);
  assign a_full = {a_sh, bus.dq_in};
  // RAM data is only guaranteed in the cycle after mem_re, so bypass it then
  assign rsrc   = re_d ? mem_rdata : rbuf;

  always_comb begin
    state_nxt = state;
    if (bus.cs_n) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (armed) state_nxt = S_CMD;
        S_CMD:   state_nxt = S_ADDR;
        S_ADDR: begin
          if (!is_rd && !is_wr) state_nxt = S_IGNORE;
          else if (cnt == 4'd0) state_nxt = is_rd ? S_DUMMY : S_WDATA;
        end
        S_DUMMY: if (cnt == 4'd0) state_nxt = S_RDATA;
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      armed      <= 1'b0;
      op         <= 8'h00;
      a_sh       <= '0;
      cnt        <= 4'd0;
      ph         <= 1'b0;
      re_d       <= 1'b0;
      rbuf       <= 8'h00;
      whi        <= 4'h0;
      addr       <= '0;
      mem_addr   <= '0;
      mem_re     <= 1'b0;
      mem_we     <= 1'b0;
      mem_wdata  <= 8'h00;
      busy       <= 1'b0;
      cmd_err    <= 1'b0;
      bus.dq_out <= 4'h0;
      bus.dq_oe  <= 4'h0;
    end else begin
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
      cmd_err   <= 1'b0;
      re_d      <= mem_re;
      busy      <= (state_nxt != S_IDLE);
      bus.dq_oe <= (state_nxt == S_RDATA) ? 4'hF : 4'h0;
      if (bus.cs_n) armed <= 1'b1;
      if (re_d) rbuf <= mem_rdata;

      case (state)
        S_IDLE: op[7:4] <= bus.dq_in;
        S_CMD: begin
          op[3:0] <= bus.dq_in;
          cnt     <= 4'd5;
        end
        S_ADDR: begin
          a_sh    <= {a_sh[15:0], bus.dq_in};
          cnt     <= cnt - 4'd1;
          cmd_err <= (state_nxt == S_IGNORE);
          if (state_nxt == S_DUMMY) begin
            mem_re   <= 1'b1;
            mem_addr <= a_full[AW-1:0];
            addr     <= a_full[AW-1:0] + AW'(1);
            cnt      <= 4'(DUMMY - 1);
          end
          if (state_nxt == S_WDATA) begin
            addr <= a_full[AW-1:0];
            ph   <= 1'b0;
          end
        end
        S_DUMMY: begin
          cnt <= cnt - 4'd1;
          if (state_nxt == S_RDATA) begin
            bus.dq_out <= rsrc[7:4];
            mem_re     <= 1'b1;
            mem_addr   <= addr;
            addr       <= addr + AW'(1);
            ph         <= 1'b1;
          end
        end
        S_RDATA: begin
          if (state_nxt == S_RDATA) begin
            ph <= ~ph;
            if (ph) begin
              bus.dq_out <= rbuf[3:0];
            end else begin
              bus.dq_out <= rsrc[7:4];
              mem_re     <= 1'b1;
              mem_addr   <= addr;
              addr       <= addr + AW'(1);
            end
          end
        end
        S_WDATA: begin
          if (state_nxt == S_WDATA) begin
            ph <= ~ph;
            if (!ph) begin
              whi <= bus.dq_in;
            end else begin
              mem_we    <= 1'b1;
              mem_wdata <= {whi, bus.dq_in};
              mem_addr  <= addr;
              addr      <= addr + AW'(1);
            end
          end
        end
        default: ;
      endcase

      if (state_nxt != S_RDATA) bus.dq_out <= 4'h0;
    end
  end

endmodule

// File: tb/tb_qspi_mem_target.sv
// Bench for qspi_mem_target: three instances (DUMMY 6, 2, 15) share one bus
// master and one RAM image; results are checked against a byte-level model.
module tb_qspi_mem_target;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic       cs_n  = 1'b1;
  logic [3:0] dq_in = 4'h0;

  qspi_mem_target_if bus0 ();
  qspi_mem_target_if bus1 ();
  qspi_mem_target_if bus2 ();
  assign bus0.cs_n = cs_n;  assign bus0.dq_in = dq_in;
  assign bus1.cs_n = cs_n;  assign bus1.dq_in = dq_in;
  assign bus2.cs_n = cs_n;  assign bus2.dq_in = dq_in;

  logic [23:0] ma0, ma1, ma2;
  logic        re0, re1, re2, we0, we1, we2;
  logic [7:0]  rd0 = 8'h00, rd1 = 8'h00, rd2 = 8'h00;
  logic [7:0]  wd0, wd1, wd2;
  logic        busy0, busy1, busy2, err0, err1, err2;

  qspi_mem_target #(.DUMMY(6)) dut0 (.clk(clk), .reset(reset), .bus(bus0),
    .mem_addr(ma0), .mem_re(re0), .mem_rdata(rd0), .mem_we(we0),
    .mem_wdata(wd0), .busy(busy0), .cmd_err(err0));
  qspi_mem_target #(.DUMMY(2)) dut1 (.clk(clk), .reset(reset), .bus(bus1),
    .mem_addr(ma1), .mem_re(re1), .mem_rdata(rd1), .mem_we(we1),
    .mem_wdata(wd1), .busy(busy1), .cmd_err(err1));
  qspi_mem_target #(.DUMMY(15)) dut2 (.clk(clk), .reset(reset), .bus(bus2),
    .mem_addr(ma2), .mem_re(re2), .mem_rdata(rd2), .mem_we(we2),
    .mem_wdata(wd2), .busy(busy2), .cmd_err(err2));

  // RAM image seen by the DUTs, and the bench's own model of memory contents
  logic [7:0] ram [int];
  logic [7:0] ref_mem [int];

  function automatic logic [7:0] init_byte(input logic [23:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction
  function automatic logic [7:0] ram_get(input logic [23:0] a);
    return ram.exists(int'(a)) ? ram[int'(a)] : init_byte(a);
  endfunction
  function automatic logic [7:0] ref_get(input logic [23:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_byte(a);
  endfunction
  function automatic void preload(input logic [23:0] a, input logic [7:0] d);
    ram[int'(a)]     = d;
    ref_mem[int'(a)] = d;
  endfunction

  logic [31:0] wr_q [$];
  int re_total0 = 0;
  int both_cnt  = 0;

  always @(posedge clk) begin
    if (we0) begin
      ram[int'(ma0)] = wd0;
      wr_q.push_back({ma0, wd0});
    end
    if (re0) begin
      rd0 <= ram_get(ma0);
      re_total0++;
    end
    if (re1) rd1 <= ram_get(ma1);
    if (re2) rd2 <= ram_get(ma2);
    if (re0 && we0) both_cnt++;
  end

  int sel = 0;
  logic [3:0] dq_s, oe_s;
  logic       busy_s, err_s;
  always_comb begin
    dq_s = bus0.dq_out; oe_s = bus0.dq_oe; busy_s = busy0; err_s = err0;
    if (sel == 1) begin
      dq_s = bus1.dq_out; oe_s = bus1.dq_oe; busy_s = busy1; err_s = err1;
    end else if (sel == 2) begin
      dq_s = bus2.dq_out; oe_s = bus2.dq_oe; busy_s = busy2; err_s = err2;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  // lg_*[i] holds what the master sees just before edge t_i
  logic [3:0] lg_dq [$];
  logic [3:0] lg_oe [$];
  logic       lg_busy [$];
  logic       lg_err [$];
  logic [3:0] wq [$];
  logic [7:0] got [$];

  task automatic tick(input logic cs, input logic [3:0] nib);
    @(negedge clk);
    lg_dq.push_back(dq_s);
    lg_oe.push_back(oe_s);
    lg_busy.push_back(busy_s);
    lg_err.push_back(err_s);
    cs_n  = cs;
    dq_in = nib;
  endtask

  task automatic clear_log();
    lg_dq.delete(); lg_oe.delete(); lg_busy.delete(); lg_err.delete();
  endtask

  task automatic tx(input logic [7:0] op, input logic [23:0] a, input int nd, input int gap);
    clear_log();
    tick(1'b0, op[7:4]);
    tick(1'b0, op[3:0]);
    for (int i = 0; i < 6; i++) tick(1'b0, a[23-4*i -: 4]);
    for (int i = 0; i < nd; i++)
      tick(1'b0, (i < wq.size()) ? wq[i] : 4'($urandom));
    tick(1'b1, 4'h0);
    for (int i = 0; i < gap; i++) tick(1'b1, 4'h0);
  endtask

  task automatic do_read(input int s, input logic [23:0] a, input int n, input int gap, input string nm);
    int d;
    d = (s == 1) ? 2 : (s == 2) ? 15 : 6;
    sel = s;
    wq.delete();
    tx(8'hEB, a, d + 2*n, gap);
    chk({nm, "_oe_before"}, lg_oe[7+d], 4'h0);
    chk({nm, "_oe_on"}, lg_oe[8+d], 4'hF);
    got.delete();
    for (int k = 0; k < n; k++) got.push_back({lg_dq[8+d+2*k], lg_dq[9+d+2*k]});
  endtask

  task automatic do_write(input logic [23:0] a, input string nm);
    int s0, nb;
    logic [23:0] ak;
    logic [7:0]  b;
    sel = 0;
    s0 = wr_q.size();
    nb = wq.size() / 2;
    tx(8'h38, a, wq.size(), 1);
    chk({nm, "_count"}, wr_q.size() - s0, nb);
    for (int k = 0; k < nb; k++) begin
      ak = a + 24'(k);
      b  = {wq[2*k], wq[2*k+1]};
      ref_mem[int'(ak)] = b;
      if (s0 + k < wr_q.size()) chk({nm, "_byte"}, wr_q[s0+k], {ak, b});
    end
  endtask

  typedef struct {
    int          s;
    logic [23:0] a;
    int          n;
    int          gap;
    logic [31:0] exp;
  } rvec_t;

  rvec_t tv [6];

  initial begin
    int s0, r0, nb, kind;
    logic [23:0] a;
    logic [3:0]  oe_or;
    logic        busy_or;

    preload(24'h000100, 8'hA5); preload(24'h000101, 8'h3C);
    preload(24'h000020, 8'h11); preload(24'h000021, 8'h22);
    preload(24'h000022, 8'h33); preload(24'h000023, 8'h44);
    preload(24'h000040, 8'h55); preload(24'h000041, 8'h66);
    preload(24'h000042, 8'h77); preload(24'h000043, 8'h88);
    preload(24'hFFFFFF, 8'hC3); preload(24'h000000, 8'h7E);

    tv[0] = '{0, 24'h000100, 2, 1, 32'h0000A53C};
    tv[1] = '{0, 24'h000020, 4, 0, 32'h11223344};
    tv[2] = '{0, 24'h000040, 4, 1, 32'h55667788};
    tv[3] = '{1, 24'h000020, 4, 1, 32'h11223344};
    tv[4] = '{2, 24'h000040, 4, 1, 32'h55667788};
    tv[5] = '{0, 24'hFFFFFF, 2, 1, 32'h0000C37E};

    repeat (3) @(negedge clk);
    chk("reset_outputs", {busy0, err0, re0, we0, bus0.dq_oe, bus0.dq_out}, 0);
    chk("reset_addr", ma0, 0);
    reset = 1'b0;
    repeat (2) tick(1'b1, 4'h0);

    for (int i = 0; i < 6; i++) begin
      do_read(tv[i].s, tv[i].a, tv[i].n, tv[i].gap, "table_rd");
      if (i > 0 && tv[i-1].gap == 0) chk("b2b_busy_clear", lg_busy[0], 1'b0);
      for (int k = 0; k < tv[i].n; k++)
        chk("table_rd_byte", got[k], tv[i].exp[8*(tv[i].n-1-k) +: 8]);
    end

    wq = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6};
    s0 = wr_q.size();
    do_write(24'hFFFFFE, "wr_wrap");
    if (wr_q.size() >= s0 + 3) chk("wr_wrap_zero", wr_q[s0+2], 32'h00000056);

    wq = '{4'h7, 4'h8, 4'h9};
    do_write(24'h000010, "wr_partial");
    chk("wr_partial_busy_before", lg_busy[11], 1'b1);
    chk("wr_partial_busy_after", lg_busy[12], 1'b0);

    sel = 0;
    wq.delete();
    s0 = wr_q.size();
    r0 = re_total0;
    tx(8'h9F, 24'h000100, 12, 1);
    chk("bad_op_err_t2", lg_err[3], 1'b1);
    chk("bad_op_err_before", lg_err[2], 1'b0);
    chk("bad_op_err_after", lg_err[4], 1'b0);
    chk("bad_op_busy", lg_busy[10], 1'b1);
    oe_or = 4'h0;
    foreach (lg_oe[i]) oe_or |= lg_oe[i];
    chk("bad_op_oe", oe_or, 4'h0);
    chk("bad_op_mem", {re_total0 - r0, wr_q.size() - s0}, 0);
    do_read(0, 24'h000100, 2, 1, "after_bad_op");
    chk("after_bad_op_data", {got[0], got[1]}, 16'hA53C);

    sel = 0;
    wq.delete();
    clear_log();
    tick(1'b0, 4'hE); tick(1'b0, 4'hB);
    for (int i = 0; i < 6; i++) tick(1'b0, (i == 3) ? 4'h1 : 4'h0);
    for (int i = 0; i < 9; i++) tick(1'b0, 4'h0);
    chk("pre_reset_oe", lg_oe[16], 4'hF);
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    clear_log();
    r0 = re_total0;
    for (int i = 0; i < 14; i++) tick(1'b0, 4'($urandom));
    oe_or = 4'h0;
    busy_or = 1'b0;
    foreach (lg_oe[i]) begin
      oe_or |= lg_oe[i];
      busy_or |= lg_busy[i];
    end
    chk("reset_mid_oe", oe_or, 4'h0);
    chk("reset_mid_busy", busy_or, 1'b0);
    chk("reset_mid_re", re_total0 - r0, 0);
    tick(1'b1, 4'h0);
    do_read(0, 24'h000100, 2, 1, "after_reset");
    chk("after_reset_data", {got[0], got[1]}, 16'hA53C);

    for (int it = 0; it < 40; it++) begin
      kind = $urandom_range(0, 1);
      a = ($urandom_range(0, 1) == 1) ? 24'h000080 + 24'($urandom_range(0, 31))
                                      : 24'hFFFFF8 + 24'($urandom_range(0, 7));
      if (kind == 1) begin
        wq.delete();
        nb = $urandom_range(0, 9);
        for (int i = 0; i < nb; i++) wq.push_back(4'($urandom));
        do_write(a, "rnd_wr");
      end else begin
        nb = $urandom_range(1, 4);
        do_read($urandom_range(0, 2), a, nb, 1, "rnd_rd");
        for (int k = 0; k < nb; k++) chk("rnd_rd_byte", got[k], ref_get(a + 24'(k)));
      end
    end

    chk("re_we_exclusive", both_cnt, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
